// File: rtl/vid_out_pkg.sv
// Shared video timing constants, derived totals and FSM encoding.
// Defaults match the upstream timing generator.
package vid_out_pkg;

  localparam int VT_H_ACTIVE = 1280;
  localparam int VT_H_FP     = 48;
  localparam int VT_H_SYNC   = 112;
  localparam int VT_H_BP     = 248;
  localparam int VT_V_ACTIVE = 1024;
  localparam int VT_V_FP     = 1;
  localparam int VT_V_SYNC   = 3;
  localparam int VT_V_BP     = 38;
  localparam int VT_HS_POL   = 1;
  localparam int VT_VS_POL   = 1;

  function automatic int tot(
    input int a,
    input int b,
    input int c,
    input int d
  );
    return a + b + c + d;
  endfunction

  localparam int VT_H_TOT =
    tot(VT_H_ACTIVE, VT_H_FP, VT_H_SYNC, VT_H_BP);
  localparam int VT_V_TOT =
    tot(VT_V_ACTIVE, VT_V_FP, VT_V_SYNC, VT_V_BP);

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    RUN        = 1'b1
  } state_t;

  function automatic logic in_rng(
    input int x,
    input int lo,
    input int hi
  );
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vid_out_if.sv
// Pixel stream in, DAC/DVI pins and status out.
// master drives the stream, slave is the output stage.
interface vid_out_if;

  logic        in_vsync;
  logic        in_req;
  logic        in_eol;
  logic        in_eof;
  logic [23:0] in_pixel;
  logic        err_clr;

  logic        vo_hsync;
  logic        vo_vsync;
  logic        vo_de;
  logic        vo_blank_;
  logic [7:0]  vo_r;
  logic [7:0]  vo_g;
  logic [7:0]  vo_b;
  logic        locked;
  logic        err_misalign;
  logic [7:0]  resync_cnt;

  modport master (
    output in_vsync, in_req, in_eol,
    output in_eof, in_pixel, err_clr,
    input  vo_hsync, vo_vsync, vo_de,
    input  vo_blank_, vo_r, vo_g, vo_b,
    input  locked, err_misalign, resync_cnt
  );

  modport slave (
    input  in_vsync, in_req, in_eol,
    input  in_eof, in_pixel, err_clr,
    output vo_hsync, vo_vsync, vo_de,
    output vo_blank_, vo_r, vo_g, vo_b,
    output locked, err_misalign, resync_cnt
  );

endinterface

// File: rtl/vid_out_cntr.sv
// Horizontal/vertical position counters with load and enable,
// plus active and sync region decodes of the current position.
module vid_out_cntr
  import vid_out_pkg::*;
#(
  parameter int H_ACTIVE = VT_H_ACTIVE,
  parameter int H_FP     = VT_H_FP,
  parameter int H_SYNC   = VT_H_SYNC,
  parameter int H_TOT    = VT_H_TOT,
  parameter int V_ACTIVE = VT_V_ACTIVE,
  parameter int V_FP     = VT_V_FP,
  parameter int V_SYNC   = VT_V_SYNC,
  parameter int V_TOT    = VT_V_TOT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [11:0] i_h_ld,
  input  logic [10:0] i_v_ld,
  output logic [11:0] o_h,
  output logic [10:0] o_v,
  output logic        o_h_act,
  output logic        o_v_act,
  output logic        o_hs,
  output logic        o_vs
);

  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;

  logic [11:0] r_h;
  logic [10:0] r_v;
  logic        w_h_end;
  logic        w_v_end;

  assign w_h_end = int'(r_h) == H_TOT - 1;
  assign w_v_end = int'(r_v) == V_TOT - 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_load) begin
      r_h <= i_h_ld;
      r_v <= i_v_ld;
    end else if (i_en) begin
      r_h <= w_h_end ? '0 : r_h + 12'd1;
      if (w_h_end)
        r_v <= w_v_end ? '0 : r_v + 11'd1;
    end
  end

  assign o_h     = r_h;
  assign o_v     = r_v;
  assign o_h_act = in_rng(int'(r_h), 0, H_ACTIVE);
  assign o_v_act = in_rng(int'(r_v), 0, V_ACTIVE);
  assign o_hs    = in_rng(int'(r_h), HS0, HS0 + H_SYNC);
  assign o_vs    = in_rng(int'(r_v), VS0, VS0 + V_SYNC);

endmodule

// File: rtl/vid_out.sv
// Final video output stage: locks its timing to the incoming vsync,
// regenerates sync/de/RGB and flags stream misalignment.
module vid_out
  import vid_out_pkg::*;
#(
  parameter int H_ACTIVE = VT_H_ACTIVE,
  parameter int H_FP     = VT_H_FP,
  parameter int H_SYNC   = VT_H_SYNC,
  parameter int H_BP     = VT_H_BP,
  parameter int V_ACTIVE = VT_V_ACTIVE,
  parameter int V_FP     = VT_V_FP,
  parameter int V_SYNC   = VT_V_SYNC,
  parameter int V_BP     = VT_V_BP,
  parameter int HS_POL   = VT_HS_POL,
  parameter int VS_POL   = VT_VS_POL
) (
  input  logic     vo_clk,
  input  logic     vo_reset,
  vid_out_if.slave bus
);

  localparam int H_TOT = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int VS_LINE = V_ACTIVE + V_FP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam logic HSP = (HS_POL != 0);
  localparam logic VSP = (VS_POL != 0);

  // Region decodes of the relock position (h = 0, first vsync line)
  localparam logic RL_DE =
    in_rng(0, 0, H_ACTIVE) && in_rng(VS_LINE, 0, V_ACTIVE);
  localparam logic RL_HS = in_rng(0, HS0, HS0 + H_SYNC);
  localparam logic RL_VS =
    in_rng(VS_LINE, VS_LINE, VS_LINE + V_SYNC);

  state_t      r_state;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [23:0] r_rgb;
  logic        r_locked;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic [11:0] w_h;
  logic [10:0] w_v;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_hs_rg;
  logic        w_vs_rg;
  logic        w_exp_req;
  logic        w_exp_eol;
  logic        w_exp_eof;
  logic        w_at_vs;
  logic        w_mis;
  logic        w_relock;
  logic        w_run;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;

  vid_out_cntr #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_TOT    (H_TOT),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_TOT    (V_TOT)
  ) u_cntr (
    .clk     (vo_clk),
    .rst     (vo_reset),
    .i_en    (r_state == RUN),
    .i_load  (w_relock),
    .i_h_ld  (12'd1),
    .i_v_ld  (11'(VS_LINE)),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_h_act (w_h_act),
    .o_v_act (w_v_act),
    .o_hs    (w_hs_rg),
    .o_vs    (w_vs_rg)
  );

  always_comb begin
    w_exp_req = w_h_act & w_v_act;
    w_exp_eol = w_exp_req & (int'(w_h) == H_ACTIVE - 1);
    w_exp_eof = w_exp_eol & (int'(w_v) == V_ACTIVE - 1);
    w_at_vs   = (w_h == 12'd0) & (int'(w_v) == VS_LINE);
    w_mis = (r_state == RUN) & (
      (bus.in_req != w_exp_req) |
      (bus.in_req & ((bus.in_eol != w_exp_eol) |
                     (bus.in_eof != w_exp_eof))) |
      (bus.in_vsync & ~w_at_vs));
    // A vsync while unlocked or misaligned relocks this very cycle
    w_relock = bus.in_vsync & ((r_state == WAIT_VSYNC) | w_mis);
    w_run    = w_relock | ((r_state == RUN) & ~w_mis);
    w_de = w_run & (w_relock ? RL_DE : (w_h_act & w_v_act));
    w_hs = w_run & (w_relock ? RL_HS : w_hs_rg);
    w_vs = w_run & (w_relock ? RL_VS : w_vs_rg);
  end

  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      r_state  <= WAIT_VSYNC;
      r_hs     <= ~HSP;
      r_vs     <= ~VSP;
      r_de     <= 1'b0;
      r_rgb    <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_run ? RUN : WAIT_VSYNC;
      r_hs     <= w_hs ? HSP : ~HSP;
      r_vs     <= w_vs ? VSP : ~VSP;
      r_de     <= w_de;
      r_rgb    <= w_de ? bus.in_pixel : '0;
      r_locked <= w_run;
      if (w_mis)
        r_err <= 1'b1;
      else if (bus.err_clr)
        r_err <= 1'b0;
      if (w_mis && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.vo_hsync     = r_hs;
  assign bus.vo_vsync     = r_vs;
  assign bus.vo_de        = r_de;
  assign bus.vo_blank_    = r_de;
  assign bus.vo_r         = r_rgb[23:16];
  assign bus.vo_g         = r_rgb[15:8];
  assign bus.vo_b         = r_rgb[7:0];
  assign bus.locked       = r_locked;
  assign bus.err_misalign = r_err;
  assign bus.resync_cnt   = r_cnt;

endmodule
